// File: rtl/msrv32_alu_core.sv
// RV32I integer ALU: add/sub, shifts, compares and logic on two 32-bit operands.
// Latency one cycle into a result register; no backpressure, accepts an op every cycle.
module msrv32_alu_core (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  input  logic [31:0] op_1_in,
  input  logic [31:0] op_2_in,
  input  logic [3:0]  opcode_in,
  output logic [31:0] result_out
);

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  logic [2:0]  funct3;
  logic        alt;
  logic [4:0]  shamt;
  logic [31:0] sum;
  logic [31:0] diff;
  logic        lt_signed;
  logic        lt_unsigned;
  logic [31:0] alu_next;

  assign funct3 = opcode_in[2:0];
  assign alt    = opcode_in[3];
  assign shamt  = op_2_in[4:0];

  assign sum         = op_1_in + op_2_in;
  assign diff        = op_1_in - op_2_in;
  assign lt_signed   = $signed(op_1_in) < $signed(op_2_in);
  assign lt_unsigned = op_1_in < op_2_in;

  // funct7[5] only matters for add/sub and logical/arithmetic right shift.
  always_comb begin
    alu_next = '0;
    case (funct3)
      F3_ADD:  alu_next = alt ? diff : sum;
      F3_SLL:  alu_next = op_1_in << shamt;
      F3_SLT:  alu_next = {31'd0, lt_signed};
      F3_SLTU: alu_next = {31'd0, lt_unsigned};
      F3_XOR:  alu_next = op_1_in ^ op_2_in;
      F3_SR:   alu_next = alt ? 32'($signed(op_1_in) >>> shamt) : (op_1_in >> shamt);
      F3_OR:   alu_next = op_1_in | op_2_in;
      F3_AND:  alu_next = op_1_in & op_2_in;
      default: alu_next = '0;
    endcase
  end

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (ms_riscv32_mp_rst_in) begin
      result_out <= '0;
    end else begin
      result_out <= alu_next;
    end
  end

endmodule

// File: tb/tb_msrv32_alu_core.sv
// Bench for msrv32_alu_core: directed vector table, pipelining/reset sequences,
// and random ops checked against an arithmetic reference model.
module tb_msrv32_alu_core;

  logic        clk;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  op;
  logic [31:0] result;

  int total = 0;
  int bad   = 0;

  msrv32_alu_core dut (
    .ms_riscv32_mp_clk_in (clk),
    .ms_riscv32_mp_rst_in (rst),
    .op_1_in              (a),
    .op_2_in              (b),
    .opcode_in            (op),
    .result_out           (result)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  // Reference computed from operand values as plain integers.
  function automatic logic [31:0] ref_alu(input logic [31:0] x, input logic [31:0] y,
                                          input logic [3:0] code);
    longint ux = longint'(x);
    longint uy = longint'(y);
    int     sxi = $signed(x);
    int     syi = $signed(y);
    longint sx = longint'(sxi);
    longint sy = longint'(syi);
    longint two32 = 64'h1_0000_0000;
    longint p = 1;
    longint r = 0;
    int     sh = int'(uy % 32);
    for (int k = 0; k < sh; k++) p = p * 2;
    if (code == 4'b1000)      r = (ux - uy + two32) % two32;
    else if (code == 4'b1101) r = (sx >= 0) ? sx / p : -((-sx + p - 1) / p);
    else begin
      case (code[2:0])
        3'd0: r = (ux + uy) % two32;
        3'd1: r = (ux * p) % two32;
        3'd2: r = (sx < sy) ? 1 : 0;
        3'd3: r = (ux < uy) ? 1 : 0;
        3'd4: r = ux ^ uy;
        3'd5: r = ux / p;
        3'd6: r = ux | uy;
        default: r = ux & uy;
      endcase
    end
    return 32'(r);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive one op away from the edge, then sample just after the edge.
  task automatic step(input logic r, input logic [3:0] o, input logic [31:0] x,
                      input logic [31:0] y);
    @(negedge clk);
    rst = r; op = o; a = x; b = y;
    @(posedge clk);
    #1;
  endtask

  vec_t vecs[$];

  initial begin
    clk = 0; rst = 1; a = 32'hDEAD_BEEF; b = 32'h1234_5678; op = 4'b0000;

    vecs.push_back('{"add",        4'b0000, 32'd20,         32'd40, 32'd60});
    vecs.push_back('{"sub",        4'b1000, 32'd40,         32'd20, 32'd20});
    vecs.push_back('{"sub_wrap",   4'b1000, 32'd0,          32'd1,  32'hFFFF_FFFF});
    vecs.push_back('{"add_ovf",    4'b0000, 32'h7FFF_FFFF,  32'd1,  32'h8000_0000});
    vecs.push_back('{"and",        4'b0111, 32'd15,         32'd7,  32'd7});
    vecs.push_back('{"or",         4'b0110, 32'd5,          32'd12, 32'd13});
    vecs.push_back('{"xor",        4'b0100, 32'd10,         32'd5,  32'd15});
    vecs.push_back('{"and_alias",  4'b1111, 32'd15,         32'd7,  32'd7});
    vecs.push_back('{"slt",        4'b0010, 32'd10,         32'd20, 32'd1});
    vecs.push_back('{"sltu",       4'b0011, 32'd20,         32'd10, 32'd0});
    vecs.push_back('{"slt_neg",    4'b0010, 32'hFFFF_FFFF,  32'd1,  32'd1});
    vecs.push_back('{"sltu_big",   4'b0011, 32'hFFFF_FFFF,  32'd1,  32'd0});
    vecs.push_back('{"slt_eq",     4'b0010, 32'd5,          32'd5,  32'd0});
    vecs.push_back('{"sll",        4'b0001, 32'd8,          32'd1,  32'd16});
    vecs.push_back('{"srl",        4'b0101, 32'd8,          32'd1,  32'd4});
    vecs.push_back('{"sra_pos",    4'b1101, 32'd8,          32'd1,  32'd4});
    vecs.push_back('{"sra_neg",    4'b1101, 32'h8000_0000,  32'd4,  32'hF800_0000});
    vecs.push_back('{"srl_msb",    4'b0101, 32'h8000_0000,  32'd4,  32'h0800_0000});
    vecs.push_back('{"sll_b5",     4'b0001, 32'd1,          32'h21, 32'd2});
    vecs.push_back('{"sll_zero",   4'b0001, 32'h1234,       32'd0,  32'h1234});
    vecs.push_back('{"sll_alias",  4'b1001, 32'd3,          32'd2,  32'd12});
    vecs.push_back('{"slt_alias",  4'b1010, 32'h8000_0000,  32'd0,  32'd1});
    vecs.push_back('{"sltu_alias", 4'b1011, 32'd1,          32'd2,  32'd1});
    vecs.push_back('{"xor_alias",  4'b1100, 32'hF0F0_F0F0,  32'hFF, 32'hF0F0_F00F});
    vecs.push_back('{"or_alias",   4'b1110, 32'h100,        32'h1,  32'h101});
    vecs.push_back('{"sra_31",     4'b1101, 32'h8000_0001,  32'hFFFF_FFFF, 32'hFFFF_FFFF});

    // Reset held two cycles clears the result regardless of inputs.
    step(1'b1, 4'b0000, 32'd1, 32'd2);
    chk("reset_1", result, 32'd0);
    step(1'b1, 4'b0110, 32'hFFFF_FFFF, 32'd0);
    chk("reset_2", result, 32'd0);

    foreach (vecs[i]) begin
      step(1'b0, vecs[i].op, vecs[i].a, vecs[i].b);
      chk(vecs[i].name, result, vecs[i].exp);
    end

    // Back-to-back ops: each result appears exactly one edge after its inputs.
    step(1'b0, 4'b0000, 32'd100, 32'd1);   chk("pipe_add", result, 32'd101);
    step(1'b0, 4'b1000, 32'd100, 32'd1);   chk("pipe_sub", result, 32'd99);
    step(1'b0, 4'b0111, 32'hF0, 32'h3C);   chk("pipe_and", result, 32'h30);
    step(1'b0, 4'b0000, 32'd100, 32'd1);   chk("pipe_add2", result, 32'd101);
    // Mid-stream reset clears on that edge, then resumes with the next inputs.
    step(1'b1, 4'b0110, 32'h5, 32'h8);     chk("mid_reset", result, 32'd0);
    step(1'b0, 4'b0110, 32'h5, 32'h8);     chk("post_reset", result, 32'hD);
    step(1'b0, 4'b1101, 32'hFFFF_FF00, 32'd4); chk("post_reset_sra", result, 32'hFFFF_FFF0);

    // Random ops, including undefined codes and occasional resets.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] x;
      logic [31:0] y;
      logic [3:0]  o;
      logic        r;
      x = $urandom;
      y = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
      if ($urandom_range(0, 7) == 0) x = {1'b1, 31'($urandom_range(0, 15))};
      o = 4'($urandom_range(0, 15));
      r = ($urandom_range(0, 31) == 0);
      step(r, o, x, y);
      chk($sformatf("rand%0d_op%b", i, o), result, r ? 32'd0 : ref_alu(x, y, o));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
